// File: rtl/bomb_pool.sv
`default_nettype none
// ============================================================================
// Module      : bomb_pool
// Description : Parametrised bomb slot manager with per-slot fuse timers,
//               explosion retire FIFO and per-pixel sprite hit lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module bomb_pool #(
  parameter int NUM_BOMBS   = 6,
  parameter int MAX_ACTIVE  = NUM_BOMBS,
  parameter int FUSE_CYCLES = 400000000,
  parameter int TIMER_W     = 32,
  parameter int COORD_W     = 10,
  parameter int BOMB_W      = 16,
  parameter int BOMB_H      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           place_btn,
  input  logic [COORD_W-1:0]             b_x,
  input  logic [COORD_W-1:0]             b_y,
  input  logic [COORD_W-1:0]             v_x,
  input  logic [COORD_W-1:0]             v_y,
  output logic                           exp_valid,
  input  logic                           exp_ready,
  output logic [COORD_W-1:0]             exp_x,
  output logic [COORD_W-1:0]             exp_y,
  output logic                           place_ok,
  output logic                           place_reject,
  output logic [$clog2(NUM_BOMBS+1)-1:0] active_count,
  output logic                           bomb_on,
  output logic [$clog2(BOMB_H)-1:0]      spr_row,
  output logic [$clog2(BOMB_W)-1:0]      spr_col
);

  localparam int CNT_W = $clog2(NUM_BOMBS + 1);
  localparam int IDX_W = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam int ROW_W = $clog2(BOMB_H);
  localparam int COL_W = $clog2(BOMB_W);
  localparam int EXT_W = COORD_W + 1;

  localparam logic [TIMER_W-1:0] C_TERMINAL   = TIMER_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_MAX_ACTIVE = CNT_W'(MAX_ACTIVE);
  localparam logic [CNT_W-1:0]   C_FIFO_DEPTH = CNT_W'(NUM_BOMBS);
  localparam logic [IDX_W-1:0]   C_LAST_PTR   = IDX_W'(NUM_BOMBS - 1);

  // slot state
  logic                 r_active [NUM_BOMBS];
  logic [TIMER_W-1:0]   r_timer  [NUM_BOMBS];
  logic [COORD_W-1:0]   r_bx     [NUM_BOMBS];
  logic [COORD_W-1:0]   r_by     [NUM_BOMBS];

  // retire FIFO
  logic [COORD_W-1:0]   r_fx     [NUM_BOMBS];
  logic [COORD_W-1:0]   r_fy     [NUM_BOMBS];
  logic [IDX_W-1:0]     r_wr_ptr;
  logic [IDX_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_fifo_cnt;

  logic                 r_btn_q;
  logic [CNT_W-1:0]     r_active_count;
  logic                 r_place_ok;
  logic                 r_place_reject;
  logic                 r_bomb_on;
  logic [ROW_W-1:0]     r_spr_row;
  logic [COL_W-1:0]     r_spr_col;

  logic [NUM_BOMBS-1:0] w_terminal;
  logic [NUM_BOMBS-1:0] w_dup_hit;
  logic [NUM_BOMBS-1:0] w_hit;
  logic [NUM_BOMBS-1:0] w_load;
  logic [NUM_BOMBS-1:0] w_clear;
  logic [ROW_W-1:0]     w_row_off [NUM_BOMBS];
  logic [COL_W-1:0]     w_col_off [NUM_BOMBS];

  logic                 w_press;
  logic                 w_dup;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_can_push;
  logic                 w_retire;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_ret_idx;
  logic                 w_hit_any;
  logic [ROW_W-1:0]     w_hit_row;
  logic [COL_W-1:0]     w_hit_col;

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + IDX_W'(1);
  endfunction

  assign w_press    = place_btn & ~r_btn_q;
  assign w_dup      = |w_dup_hit;
  assign w_accept   = w_press && (r_active_count < C_MAX_ACTIVE) && !w_dup;
  assign w_pop      = exp_valid && exp_ready;
  assign w_can_push = (r_fifo_cnt != C_FIFO_DEPTH) || w_pop;
  assign w_retire   = (|w_terminal) && w_can_push;

  // Lowest index wins for free slot, retiring slot and pixel hit alike.
  always_comb begin
    w_free_idx = '0;
    w_ret_idx  = '0;
    w_hit_any  = 1'b0;
    w_hit_row  = '0;
    w_hit_col  = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!r_active[i]) w_free_idx = IDX_W'(i);
      if (w_terminal[i]) w_ret_idx = IDX_W'(i);
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_row = w_row_off[i];
        w_hit_col = w_col_off[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
    logic [EXT_W-1:0] w_x_hi;
    logic [EXT_W-1:0] w_y_hi;

    // Extended width keeps x+BOMB_W-1 from wrapping at the screen edge.
    assign w_x_hi = {1'b0, r_bx[g]} + EXT_W'(BOMB_W - 1);
    assign w_y_hi = {1'b0, r_by[g]} + EXT_W'(BOMB_H - 1);

    assign w_terminal[g] = r_active[g] && (r_timer[g] == C_TERMINAL);
    assign w_dup_hit[g]  = r_active[g] && (r_bx[g] == b_x) && (r_by[g] == b_y);
    assign w_load[g]     = w_accept && (w_free_idx == IDX_W'(g));
    assign w_clear[g]    = w_retire && (w_ret_idx == IDX_W'(g));
    assign w_hit[g]      = r_active[g]
                           && ({1'b0, v_x} >= {1'b0, r_bx[g]}) && ({1'b0, v_x} <= w_x_hi)
                           && ({1'b0, v_y} >= {1'b0, r_by[g]}) && ({1'b0, v_y} <= w_y_hi);
    assign w_row_off[g]  = ROW_W'(v_y - r_by[g]);
    assign w_col_off[g]  = COL_W'(v_x - r_bx[g]);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_active[g] <= 1'b0;
        r_timer[g]  <= '0;
        r_bx[g]     <= '0;
        r_by[g]     <= '0;
      end else if (w_load[g]) begin
        r_active[g] <= 1'b1;
        r_timer[g]  <= '0;
        r_bx[g]     <= b_x;
        r_by[g]     <= b_y;
      end else if (w_clear[g]) begin
        r_active[g] <= 1'b0;
        r_timer[g]  <= '0;
      end else if (r_active[g] && !w_terminal[g]) begin
        r_timer[g]  <= r_timer[g] + TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        r_fx[i] <= '0;
        r_fy[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_retire) begin
        r_fx[r_wr_ptr] <= r_bx[w_ret_idx];
        r_fy[r_wr_ptr] <= r_by[w_ret_idx];
        r_wr_ptr       <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_retire, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_q        <= 1'b0;
      r_active_count <= '0;
      r_place_ok     <= 1'b0;
      r_place_reject <= 1'b0;
      r_bomb_on      <= 1'b0;
      r_spr_row      <= '0;
      r_spr_col      <= '0;
    end else begin
      r_btn_q        <= place_btn;
      r_place_ok     <= w_accept;
      r_place_reject <= w_press && !w_accept;
      r_bomb_on      <= w_hit_any;
      r_spr_row      <= w_hit_row;
      r_spr_col      <= w_hit_col;
      case ({w_accept, w_retire})
        2'b10:   r_active_count <= r_active_count + CNT_W'(1);
        2'b01:   r_active_count <= r_active_count - CNT_W'(1);
        default: r_active_count <= r_active_count;
      endcase
    end
  end

  assign exp_valid    = (r_fifo_cnt != '0);
  assign exp_x        = r_fx[r_rd_ptr];
  assign exp_y        = r_fy[r_rd_ptr];
  assign place_ok     = r_place_ok;
  assign place_reject = r_place_reject;
  assign active_count = r_active_count;
  assign bomb_on      = r_bomb_on;
  assign spr_row      = r_spr_row;
  assign spr_col      = r_spr_col;

endmodule
`default_nettype wire

// File: tb/tb_bomb_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_bomb_pool
// Description : Directed plus random stimulus on two bomb_pool instances
//               (MAX_ACTIVE 3 and 4) against a slot/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_pool;

  localparam int F  = 20;
  localparam int NB = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          place_btn = 1'b0;
  logic          exp_ready = 1'b0;
  logic [CW-1:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;

  logic [1:0]    ev, ok, rej, bon;
  logic [CW-1:0] ex [2];
  logic [CW-1:0] ey [2];
  logic [2:0]    ac [2];
  logic [3:0]    row [2];
  logic [3:0]    col [2];

  always #5 clk = ~clk;

  bomb_pool #(.NUM_BOMBS(NB), .MAX_ACTIVE(3), .FUSE_CYCLES(F), .TIMER_W(8),
              .COORD_W(CW), .BOMB_W(16), .BOMB_H(16)) dut3 (
    .clk(clk), .reset(reset), .place_btn(place_btn), .b_x(b_x), .b_y(b_y),
    .v_x(v_x), .v_y(v_y), .exp_valid(ev[0]), .exp_ready(exp_ready),
    .exp_x(ex[0]), .exp_y(ey[0]), .place_ok(ok[0]), .place_reject(rej[0]),
    .active_count(ac[0]), .bomb_on(bon[0]), .spr_row(row[0]), .spr_col(col[0]));

  bomb_pool #(.NUM_BOMBS(NB), .MAX_ACTIVE(4), .FUSE_CYCLES(F), .TIMER_W(8),
              .COORD_W(CW), .BOMB_W(16), .BOMB_H(16)) dut4 (
    .clk(clk), .reset(reset), .place_btn(place_btn), .b_x(b_x), .b_y(b_y),
    .v_x(v_x), .v_y(v_y), .exp_valid(ev[1]), .exp_ready(exp_ready),
    .exp_x(ex[1]), .exp_y(ey[1]), .place_ok(ok[1]), .place_reject(rej[1]),
    .active_count(ac[1]), .bomb_on(bon[1]), .spr_row(row[1]), .spr_col(col[1]));

  // Reference model: bombs remember the cycle they appeared; expiry is age-based.
  int          cyc;
  bit          m_btnq;
  bit          m_act  [2][NB];
  int          m_born [2][NB];
  int          m_x    [2][NB];
  int          m_y    [2][NB];
  logic [19:0] q0 [$];
  logic [19:0] q1 [$];
  bit          m_ok [2], m_rej [2], m_bon [2];
  int          m_row [2], m_col [2];
  int          maxa [2] = '{3, 4};
  int          checks = 0;
  int          failures = 0;

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [19:0] qhead(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_btnq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NB; i++) begin
        m_act[k][i] = 1'b0; m_born[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
      end
      m_ok[k] = 1'b0; m_rej[k] = 1'b0; m_bon[k] = 1'b0; m_row[k] = 0; m_col[k] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge();
    bit press, dup, pop, acc, found;
    int cnt, fr, rt, qs, vx, vy, bx, by;
    logic [19:0] e;
    press = place_btn && !m_btnq;
    vx = int'(v_x); vy = int'(v_y); bx = int'(b_x); by = int'(b_y);
    for (int k = 0; k < 2; k++) begin
      cnt = 0; dup = 1'b0; fr = -1; rt = -1; found = 1'b0;
      m_bon[k] = 1'b0; m_row[k] = 0; m_col[k] = 0;
      for (int i = 0; i < NB; i++) begin
        if (m_act[k][i]) begin
          cnt = cnt + 1;
          if (m_x[k][i] == bx && m_y[k][i] == by) dup = 1'b1;
          if (cyc - m_born[k][i] >= F - 1 && rt < 0) rt = i;
          if (!found && vx >= m_x[k][i] && vx <= m_x[k][i] + 15 &&
              vy >= m_y[k][i] && vy <= m_y[k][i] + 15) begin
            found = 1'b1;
            m_bon[k] = 1'b1;
            m_row[k] = vy - m_y[k][i];
            m_col[k] = vx - m_x[k][i];
          end
        end else if (fr < 0) begin
          fr = i;
        end
      end
      qs  = qsize(k);
      pop = (qs > 0) && exp_ready;
      acc = press && (cnt < maxa[k]) && !dup;
      if (pop) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (rt >= 0 && (qs < NB || pop)) begin
        e = {CW'(m_x[k][rt]), CW'(m_y[k][rt])};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        m_act[k][rt] = 1'b0;
      end
      if (acc) begin
        m_act[k][fr] = 1'b1; m_born[k][fr] = cyc + 1; m_x[k][fr] = bx; m_y[k][fr] = by;
      end
      m_ok[k]  = acc;
      m_rej[k] = press && !acc;
    end
    m_btnq = place_btn;
    cyc = cyc + 1;
  endtask

  task automatic check_outputs();
    int a, qs;
    logic [19:0] h;
    for (int k = 0; k < 2; k++) begin
      a = 0;
      for (int i = 0; i < NB; i++) a = a + int'(m_act[k][i]);
      qs = qsize(k);
      chk("exp_valid", k, 32'(ev[k]), 32'(qs != 0));
      if (qs != 0) begin
        h = qhead(k);
        chk("exp_x", k, 32'(ex[k]), 32'(h[19:10]));
        chk("exp_y", k, 32'(ey[k]), 32'(h[9:0]));
      end
      chk("place_ok", k, 32'(ok[k]), 32'(m_ok[k]));
      chk("place_reject", k, 32'(rej[k]), 32'(m_rej[k]));
      chk("active_count", k, 32'(ac[k]), 32'(a));
      chk("bomb_on", k, 32'(bon[k]), 32'(m_bon[k]));
      chk("spr_row", k, 32'(row[k]), 32'(m_row[k]));
      chk("spr_col", k, 32'(col[k]), 32'(m_col[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input int x, input int y);
    b_x = CW'(x); b_y = CW'(y); place_btn = 1'b1;
    step();
    place_btn = 1'b0;
    step();
  endtask

  task automatic do_reset();
    place_btn = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("exp_x_rst", k, 32'(ex[k]), 32'd0);
      chk("exp_y_rst", k, 32'(ey[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  int px [6] = '{0, 32, 100, 500, 1015, 1020};
  int py [6] = '{0, 48, 200, 700, 1008, 1020};

  initial begin
    cyc = 0;
    do_reset();

    // held button places one bomb; entry waits in FIFO until ready
    exp_ready = 1'b0;
    b_x = 10'd32; b_y = 10'd48; place_btn = 1'b1;
    run(10);
    place_btn = 1'b0;
    run(25);
    exp_ready = 1'b1;
    run(3);

    // four distinct presses, then a duplicate of an active position
    exp_ready = 1'b0;
    press(10, 10); press(40, 10); press(70, 10); press(100, 10);
    press(10, 10);
    // fill FIFO on the 4-slot instance, then one more bomb that must hold
    run(25);
    press(300, 300);
    run(25);
    exp_ready = 1'b1;
    step();
    exp_ready = 1'b0;
    run(3);
    exp_ready = 1'b1;
    run(8);

    // back-to-back presses, draining as they expire
    press(5, 6); press(7, 8);
    run(25);

    // sprite scan around (100,200)
    press(100, 200);
    v_x = 10'd100; v_y = 10'd200; step();
    v_x = 10'd115; v_y = 10'd215; step();
    v_x = 10'd116; v_y = 10'd200; step();
    v_x = 10'd99;  v_y = 10'd200; step();
    run(25);

    // mid-fuse reset
    press(400, 400); press(420, 400);
    run(5);
    v_x = 10'd400; v_y = 10'd400;
    run(2);
    do_reset();
    run(3);

    // random traffic including right/bottom edge positions
    for (int n = 0; n < 800; n++) begin
      int p, s;
      p = int'($urandom_range(0, 5));
      s = int'($urandom_range(0, 5));
      place_btn = ($urandom_range(0, 3) == 0);
      b_x = CW'(px[p]); b_y = CW'(py[p]);
      v_x = CW'(px[s] + int'($urandom_range(0, 18)) - 1);
      v_y = CW'(py[s] + int'($urandom_range(0, 18)) - 1);
      exp_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
